// File: rtl/mult_unit.sv
// 32x32 sequential shift-add multiplier, signed or unsigned, one step per falling clock edge.
// The FSM idles until start, runs 32 steps, then holds done for one cycle while hi/lo hold the new product.
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [64:0] acc;
    logic [5:0]  cnt;
    logic        neg;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_in;
    logic [32:0] upper_sum;
    logic [64:0] acc_next;
    logic [63:0] prod;

    always_comb begin
        a_mag  = (signed_op && a[31]) ? (32'd0 - a) : a;
        b_mag  = (signed_op && b[31]) ? (32'd0 - b) : b;
        // A zero operand always gives a positive result.
        neg_in = signed_op && (a[31] ^ b[31]) && (a != 32'd0) && (b != 32'd0);

        upper_sum = acc[64:32] + (mplier[0] ? {1'b0, mcand} : 33'd0);
        acc_next  = {1'b0, upper_sum, acc[31:1]};
        prod      = neg ? (64'd0 - acc_next[63:0]) : acc_next[63:0];
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 65'd0;
            cnt    <= 6'd0;
            neg    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= neg_in;
                        acc    <= 65'd0;
                        cnt    <= 6'd0;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on the falling edge, matching the downstream negative-edge result registers.
REQ-003 reset  input  1  synchronous, active-high; sampled on the falling edge of clk.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 a  input  32  multiplicand; captured with start.
REQ-007 b  input  32  multiplier; captured with start.
REQ-008 busy  output  1  high while an operation is iterating (RUN).
REQ-009 done  output  1  one-cycle pulse; hi/lo hold the new product while high. Drives the downstream HI/LO register enables.
REQ-010 hi  output  32  upper 32 bits of the 64-bit product.
REQ-011 lo  output  32  lower 32 bits of the 64-bit product.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE -> RUN on a falling edge with start=1. That edge captures a, b and signed_op, and clears the internal accumulator and iteration counter.
REQ-014 Signed capture: each operand with bit31=1 is stored as its two's-complement magnitude; result sign = a[31] XOR b[31]. Unsigned capture stores operands unchanged; result sign = 0.
REQ-015 0x80000000 in signed mode has magnitude 2^31, held in the 32-bit unsigned operand register without overflow.
REQ-016 RUN performs one shift-add step per cycle:
  - if the multiplier LSB is 1, add the multiplicand to the upper 33 bits of the 65-bit accumulator (33 bits including carry);
  - then shift the accumulator right by 1.
REQ-017 Iteration counter: 6 bits, counts 0..31. RUN lasts exactly 32 cycles.
REQ-018 On the 32nd RUN edge the FSM -> DONE. The same edge loads hi/lo with the final 64-bit product, negated (two's complement over 64 bits) if the result sign is 1.
REQ-019 DONE lasts exactly one cycle, then the FSM -> IDLE unconditionally.
REQ-020 Latency: start sampled at edge E0; done=1 in the cycle following edge E32; the FSM is back in IDLE after edge E33.
REQ-021 busy = 1 exactly in RUN. done = 1 exactly in DONE. busy and done are never high together.
REQ-022 start is ignored in RUN and DONE. No queuing; a, b and signed_op changes during RUN have no effect.
REQ-023 Earliest back-to-back start: sampled at the edge that returns the FSM to IDLE? No — start is sampled in the first IDLE cycle after DONE. Minimum start-to-start spacing is 34 cycles.
REQ-024 hi/lo change only on the completion edge (REQ-018) or on reset, and hold the last product indefinitely otherwise.
REQ-025 Zero operands: the operation still takes the full 32 cycles; result is 0 with sign forced 0 (no negative zero issue in 64-bit two's complement).
REQ-026 Arithmetic is exact for all inputs. The 64-bit signed range covers every product, including (-2^31)*(-2^31) = 2^62. There is no overflow flag.

Reset
REQ-027 reset=1 at a falling edge forces the following, regardless of current state, including mid-RUN:
  - FSM to IDLE; busy=0; done=0;
  - hi=0; lo=0;
  - accumulator, operand registers and counter to 0.
REQ-028 reset has priority over start on the same edge; the operation is discarded and must be reissued.
REQ-029 The first start is accepted at the first falling edge with reset=0.

Verification
REQ-030 Unsigned 3 x 5, start at E0 -> busy high E0..E32, done pulse after E32; hi=0x00000000, lo=0x0000000F.
REQ-031 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Signed mode with the same operands -> hi=0x00000000, lo=0x00000001.
REQ-032 Signed 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 Unsigned 7 x 6 completes, then reset asserted at the 10th RUN cycle of a new start -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows, even after 40 further idle cycles.
REQ-034 start held high continuously with new a/b each cycle -> only the operands of the accepted start affect the result. Done pulses are spaced exactly 34 cycles apart. hi/lo are stable between pulses.
